bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter: the stage directly upstream of the seven-segment scan driver on the Basys3 CPU top. It accepts a binary result word from the CPU result register, converts it with an iterative shift-add-3 (double-dabble) algorithm one bit per cycle, and presents a packed BCD digit vector that the display consumes directly. It replaces wide combinational divide/modulo logic with a small, timing-friendly datapath.

## Interface
- DATA_W, 32: binary input width; latency scales with it.
- DIGITS, 8: BCD output digits; legal range 1..9 for DATA_W=32.
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, synchronous, active-high.
- in_data  in  DATA_W  binary value to convert.
- in_valid  in  1  request; accepted when in_valid & in_ready.
- in_ready  out  1  high only in IDLE.
- bcd_out  out  4*DIGITS  packed digits, digit 0 (ones) in bits [3:0].
- out_valid  out  1  one-cycle pulse when bcd_out is updated.
- ovf  out  1  input was ≥ 10^DIGITS; held with bcd_out.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On accept: latch in_data into shift register, clear BCD accumulator, bit counter=0, compute ovf_next = (in_data ≥ 10^DIGITS) using a 64-bit constant compare; go SHIFT.
- SHIFT: each cycle, every accumulator digit ≥5 gets +3, then {acc, shreg} shifts left by 1. Counter increments; after DATA_W shifts go DONE.
- DONE: load bcd_out (all digits 4'h9 if ovf_next, else accumulator), load ovf, pulse out_valid; return IDLE.
- bcd_out/ovf hold until the next DONE; never change mid-conversion.
- Carries out of the top digit are discarded; overflow is reported only via the compare, never via the accumulator.
- in_valid while not in IDLE is ignored (no queueing); upstream must hold it until in_ready.
- Width rule: counter is $clog2(DATA_W+1) bits; accumulator exactly 4*DIGITS bits.

## Timing
- Reset values: state IDLE, bcd_out 0, ovf 0, out_valid 0, counter 0; in_ready reads 1 after reset, inputs ignored while rst=1.
- Accept at edge N → out_valid high in cycle N+DATA_W+1 (33 for default).
- Throughput: one conversion per DATA_W+2 cycles (in_ready low during SHIFT and DONE).
- rst mid-SHIFT or in DONE: aborts, no out_valid, outputs return to reset values next edge.
- rst and in_valid in same cycle: reset wins, request dropped.

## Configuration
- BIN2BCD_BLANK_EN defined: in DONE, leading zero digits (above the highest non-zero digit) are written as 4'hF (blank code); digit 0 is never blanked; overflow pattern not blanked. Display decodes 4'hF as all segments off.
- Undefined: leading zeros emitted as 4'h0. Ports and latency identical in both builds.

## Structure
- Package bin2bcd_pkg: state encoding constants, BCD_BLANK = 4'hF, pow10 constant function for the overflow threshold.
- One sub-module: bcd_add3 (4-bit in, 4-bit out, +3 if ≥5), instantiated DIGITS times in a generate loop.

## Test plan
- in_data=255 → out_valid exactly 33 cycles after accept, bcd_out=0x00000255, ovf=0 (blank build: 0xFFFFF255).
- in_data=0 → bcd_out=0x00000000 (blank build: 0xFFFFFFF0), ovf=0.
- in_data=99999999 → bcd_out=0x99999999, ovf=0; in_data=100000000 → bcd_out=0x99999999, ovf=1.
- in_valid held during SHIFT with new data 7 → ignored until in_ready; second result 0x00000007 (blank: 0xFFFFFFF7) 34 cycles after first out_valid.
- rst asserted at shift 10 of converting 12345 → no out_valid, bcd_out=0, in_ready=1 after reset deasserts; next 12345 yields 0x00012345.
- Back-to-back 1, 10, 100 with in_valid held high → three out_valid pulses 34 cycles apart, values 0x00000001, 0x00000010, 0x00000100.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: state encodings, blank digit code and the power-of-ten helper for the overflow limit
package bin2bcd_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [3:0] BCD_BLANK = 4'hF;
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 when the digit is 5 or more
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-cycle shift-add-3 binary to packed BCD converter
// BIN2BCD_BLANK_EN: write leading zero digits as BCD_BLANK
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid,
    output logic                  ovf
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS);
    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   shreg;
    logic [4*DIGITS-1:0] acc, acc_adj, result;
    logic                ovf_next;
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (.d(acc[4*g +: 4]), .q(acc_adj[4*g +: 4]));
    end
    assign in_ready = (state == ST_IDLE);
`ifdef BIN2BCD_BLANK_EN
    logic seen;
    // Digits above the highest non-zero one are blanked; digit 0 always shows
    always_comb begin
        seen = 1'b0;
        result = acc;
        for (int i = DIGITS - 1; i > 0; i--) begin
            seen = seen | (acc[4*i +: 4] != 4'h0);
            result[4*i +: 4] = seen ? acc[4*i +: 4] : BCD_BLANK;
        end
    end
`else
    assign result = acc;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            acc       <= '0;
            ovf_next  <= 1'b0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == ST_IDLE) begin
                if (in_valid) begin
                    shreg    <= in_data;
                    acc      <= '0;
                    cnt      <= '0;
                    ovf_next <= 64'(in_data) >= LIMIT;
                    state    <= ST_SHIFT;
                end
            end else if (state == ST_SHIFT) begin
                // Carries out of the top digit fall off; overflow comes only from the compare
                {acc, shreg} <= {acc_adj, shreg} << 1;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(DATA_W - 1)) state <= ST_DONE;
            end else if (state == ST_DONE) begin
                bcd_out   <= ovf_next ? {DIGITS{4'h9}} : result;
                ovf       <= ovf_next;
                out_valid <= 1'b1;
                state     <= ST_IDLE;
            end else begin
                state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed checks of bin2bcd_seq latency, values, overflow, reset abort and throughput
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bcd_out;
    logic        out_valid;
    logic        ovf;
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;

    bin2bcd_seq #(.DATA_W(32), .DIGITS(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .bcd_out(bcd_out), .out_valid(out_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] pick(input logic [31:0] plain, input logic [31:0] blank);
`ifdef BIN2BCD_BLANK_EN
        return blank;
`else
        return plain;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_ov(output int stamp);
        int n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        stamp = cyc;
    endtask

    task automatic convert(input logic [31:0] v, output int lat);
        int n = 0;
        int start, stamp;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        start = cyc;
        wait_ov(stamp);
        lat = stamp - start;
    endtask

    initial begin
        int lat, s1, s2, s3, cnt;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'd5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_bcd", bcd_out, 32'h0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("rst_req_dropped", 32'(cnt), 32'd0);

        convert(32'd255, lat);
        check("lat_255", 32'(lat), 32'd33);
        check("bcd_255", bcd_out, pick(32'h00000255, 32'hFFFFF255));
        check("ovf_255", 32'(ovf), 32'd0);
        @(negedge clk);
        check("pulse_255", 32'(out_valid), 32'd0);
        check("hold_255", bcd_out, pick(32'h00000255, 32'hFFFFF255));

        convert(32'd0, lat);
        check("bcd_0", bcd_out, pick(32'h00000000, 32'hFFFFFFF0));
        check("ovf_0", 32'(ovf), 32'd0);

        convert(32'd99999999, lat);
        check("bcd_max", bcd_out, 32'h99999999);
        check("ovf_max", 32'(ovf), 32'd0);

        convert(32'd100000000, lat);
        check("bcd_ovf", bcd_out, 32'h99999999);
        check("ovf_ovf", 32'(ovf), 32'd1);

        // Request held high during SHIFT with new data must wait for IDLE
        in_data  = 32'd12;
        in_valid = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        in_data = 32'd7;
        check("busy_in_ready", 32'(in_ready), 32'd0);
        wait_ov(s1);
        check("first_12", bcd_out, pick(32'h00000012, 32'hFFFFFF12));
        check("first_12_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        wait_ov(s2);
        in_valid = 1'b0;
        check("second_7", bcd_out, pick(32'h00000007, 32'hFFFFFFF7));
        check("second_gap", 32'(s2 - s1), 32'd34);

        // Reset during the tenth shift aborts the conversion
        @(negedge clk);
        in_data  = 32'd12345;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_bcd", bcd_out, 32'h0);
        check("abort_ovf", 32'(ovf), 32'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("abort_no_valid", 32'(cnt), 32'd0);
        convert(32'd12345, lat);
        check("lat_12345", 32'(lat), 32'd33);
        check("bcd_12345", bcd_out, pick(32'h00012345, 32'hFFF12345));

        // Back-to-back with in_valid held high
        @(negedge clk);
        in_data  = 32'd1;
        in_valid = 1'b1;
        @(negedge clk);
        wait_ov(s1);
        check("b2b_1", bcd_out, pick(32'h00000001, 32'hFFFFFFF1));
        in_data = 32'd10;
        @(negedge clk);
        wait_ov(s2);
        check("b2b_10", bcd_out, pick(32'h00000010, 32'hFFFFFF10));
        check("b2b_gap1", 32'(s2 - s1), 32'd34);
        in_data = 32'd100;
        @(negedge clk);
        wait_ov(s3);
        in_valid = 1'b0;
        check("b2b_100", bcd_out, pick(32'h00000100, 32'hFFFFF100));
        check("b2b_gap2", 32'(s3 - s2), 32'd34);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
